// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage feeding the control decoder.
//
// Holds the program counter and issues one word-aligned request at a time
// to instruction memory. Each returned word is registered and offered
// downstream under valid/ready. Fetch stops for good once the stop
// instruction (opcode 7'b1111111) has been accepted downstream.
//
// Ports:
//   i_clk, i_rst     clock; synchronous active-high reset
//   o_i_addr         instruction-memory address (current PC)
//   o_i_valid_addr   one-cycle request strobe
//   i_i_valid_inst   memory response valid (honoured only while waiting)
//   i_i_inst         memory response data
//   o_inst           registered instruction to the decoder
//   o_inst_valid     o_inst holds an unconsumed instruction
//   i_inst_ready     downstream accepts o_inst this cycle
//   o_pc             PC of the instruction in o_inst
//   o_halted         stop instruction consumed; fetch idle until reset
//   o_fetch_cnt      instructions accepted downstream (wraps)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | post-reset settle; one full clock after reset release
// REQ   | request strobe high for exactly one cycle, address = PC
// WAIT  | waiting for the memory response, no timeout
// HOLD  | instruction presented downstream until accepted
// HALT  | stop instruction accepted; all strobes low until reset

module inst_fetch #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic [ADDR_W-1:0] o_i_addr,
  output logic              o_i_valid_addr,
  input  logic              i_i_valid_inst,
  input  logic [INST_W-1:0] i_i_inst,
  output logic [INST_W-1:0] o_inst,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_halted,
  output logic [31:0]       o_fetch_cnt
);

  localparam logic [6:0] STOP_OP = 7'b1111111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALT
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                rst_hold_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [INST_W-1:0]   inst_q;
  logic [ADDR_W-1:0]   inst_pc_q;
  logic [31:0]         cnt_q;
  logic                capture;
  logic                accept;
  logic                is_stop;

  assign is_stop = (inst_q[6:0] == STOP_OP);

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    accept  = 1'b0;
    case (state_q)
      // The first edge after reset release keeps IDLE, so IDLE is a whole
      // clock with reset low before the first request goes out.
      S_IDLE: if (!rst_hold_q) state_d = S_REQ;
      S_REQ:  state_d = S_WAIT;
      S_WAIT: begin
        if (i_i_valid_inst) begin
          capture = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (i_inst_ready) begin
          accept  = 1'b1;
          state_d = is_stop ? S_HALT : S_REQ;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      rst_hold_q <= 1'b1;
      pc_q       <= '0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rst_hold_q <= 1'b0;
      if (capture) begin
        inst_q    <= i_i_inst;
        inst_pc_q <= pc_q;
      end
      if (accept) begin
        cnt_q <= cnt_q + 32'd1;
        if (!is_stop) pc_q <= pc_q + ADDR_W'(4);
      end
    end
  end

  // All outputs come from registers only; no input reaches an output
  // combinationally.
  assign o_i_addr       = pc_q;
  assign o_i_valid_addr = (state_q == S_REQ);
  assign o_inst         = inst_q;
  assign o_inst_valid   = (state_q == S_HOLD);
  assign o_pc           = inst_pc_q;
  assign o_halted       = (state_q == S_HALT);
  assign o_fetch_cnt    = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a behavioural instruction memory pushes
// each returned word and its address into a scoreboard queue; the main
// sequence pops it when the DUT presents the instruction downstream.
module tb_inst_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 64-bit instance
  logic        rst;
  logic        ready;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_data  = 32'h0;
  logic        spur      = 1'b0;
  logic        i_i_valid_inst;
  logic [31:0] i_i_inst;
  logic [63:0] o_i_addr;
  logic        o_i_valid_addr;
  logic [31:0] o_inst;
  logic        o_inst_valid;
  logic [63:0] o_pc;
  logic        o_halted;
  logic [31:0] o_fetch_cnt;

  assign i_i_valid_inst = mem_valid | spur;
  assign i_i_inst       = spur ? 32'hDEADBEEF : mem_data;

  inst_fetch #(.ADDR_W(64), .INST_W(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_i_addr(o_i_addr), .o_i_valid_addr(o_i_valid_addr),
    .i_i_valid_inst(i_i_valid_inst), .i_i_inst(i_i_inst),
    .o_inst(o_inst), .o_inst_valid(o_inst_valid), .i_inst_ready(ready),
    .o_pc(o_pc), .o_halted(o_halted), .o_fetch_cnt(o_fetch_cnt)
  );

  // 8-bit address instance for the PC wrap case
  logic        rst8;
  logic        ready8;
  logic        v8 = 1'b0;
  logic [31:0] inst8 = 32'h00000013;
  logic [7:0]  o_i_addr8;
  logic        o_i_valid_addr8;
  logic [31:0] o_inst8;
  logic        o_inst_valid8;
  logic [7:0]  o_pc8;
  logic        o_halted8;
  logic [31:0] o_fetch_cnt8;

  inst_fetch #(.ADDR_W(8), .INST_W(32)) dut8 (
    .i_clk(clk), .i_rst(rst8),
    .o_i_addr(o_i_addr8), .o_i_valid_addr(o_i_valid_addr8),
    .i_i_valid_inst(v8), .i_i_inst(inst8),
    .o_inst(o_inst8), .o_inst_valid(o_inst_valid8), .i_inst_ready(ready8),
    .o_pc(o_pc8), .o_halted(o_halted8), .o_fetch_cnt(o_fetch_cnt8)
  );

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog [0:15];
  int          lat  = 1;
  bit          drop = 1'b0;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] model_pc;
  int          model_cnt;

  // Memory for the 64-bit instance: latency lat cycles, one response per request.
  initial begin : mem_model
    logic [63:0] a;
    forever begin
      @(negedge clk);
      if (o_i_valid_addr === 1'b1) begin
        a = o_i_addr;
        @(posedge clk);
        repeat (lat - 1) @(posedge clk);
        #1;
        mem_data  = prog[a[5:2]];
        mem_valid = 1'b1;
        if (!drop) sb.push_back('{inst: prog[a[5:2]], pc: a});
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
      end
    end
  end

  // Memory for the 8-bit instance: latency 1, always returns a nop.
  initial begin : mem8_model
    forever begin
      @(negedge clk);
      if (o_i_valid_addr8 === 1'b1) begin
        @(posedge clk);
        #1 v8 = 1'b1;
        @(posedge clk);
        #1 v8 = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_valid_addr", 64'(o_i_valid_addr), 64'd0);
    chk("rst_addr", o_i_addr, 64'd0);
    chk("rst_inst", 64'(o_inst), 64'd0);
    chk("rst_pc", o_pc, 64'd0);
    chk("rst_inst_valid", 64'(o_inst_valid), 64'd0);
    chk("rst_halted", 64'(o_halted), 64'd0);
    chk("rst_fetch_cnt", 64'(o_fetch_cnt), 64'd0);
  endtask

  // Fetch n instructions; downstream holds ready low for `hold` HOLD cycles.
  task automatic run_insts(input int n, input int hold, input bit spur_on, output int first_req);
    int   prev_req;
    int   w;
    int   extra;
    exp_t e;
    first_req = -1;
    prev_req  = -1;
    for (int k = 0; k < n; k++) begin
      w = 0;
      while (o_i_valid_addr !== 1'b1 && w < 100) begin
        @(negedge clk);
        w++;
      end
      chk("req_seen", 64'(o_i_valid_addr), 64'd1);
      chk("req_addr", o_i_addr, model_pc);
      if (k == 0) first_req = cyc;
      else chk("req_spacing", 64'(cyc - prev_req), 64'(lat + 2 + hold));
      prev_req = cyc;
      if (spur_on && k == 0) spur = 1'b1;
      @(negedge clk);
      spur  = 1'b0;
      w     = 1;
      extra = 0;
      while (o_inst_valid !== 1'b1 && w < 100) begin
        if (o_i_valid_addr !== 1'b0) extra++;
        @(negedge clk);
        w++;
      end
      chk("latency", 64'(w), 64'(lat + 1));
      chk("no_second_req", 64'(extra), 64'd0);
      chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) e = sb.pop_front();
      else e = '{inst: 32'h0, pc: 64'h0};
      for (int hc = 0; hc < hold; hc++) begin
        chk("hold_inst", 64'(o_inst), 64'(e.inst));
        chk("hold_pc", o_pc, e.pc);
        chk("hold_valid", 64'(o_inst_valid), 64'd1);
        chk("hold_no_req", 64'(o_i_valid_addr), 64'd0);
        if (spur_on && k == 0 && hc == 0) spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
      end
      chk("acc_inst", 64'(o_inst), 64'(e.inst));
      chk("acc_pc", o_pc, e.pc);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      model_cnt++;
      chk("valid_drop", 64'(o_inst_valid), 64'd0);
      chk("fetch_cnt", 64'(o_fetch_cnt), 64'(model_cnt));
      if (e.inst[6:0] == 7'h7F) begin
        chk("halted", 64'(o_halted), 64'd1);
      end else begin
        chk("not_halted", 64'(o_halted), 64'd0);
        model_pc = model_pc + 64'd4;
      end
    end
  endtask

  initial begin : main
    int          first;
    int          rel;
    int          hits;
    int          n8;
    int          bad8;
    int          w8;
    logic [7:0]  exp8;
    logic [7:0]  a63;

    rst    = 1'b1;
    ready  = 1'b0;
    rst8   = 1'b1;
    ready8 = 1'b1;
    for (int i = 0; i < 16; i++) prog[i] = 32'h00000013;
    prog[0] = 32'h00000013;
    prog[1] = 32'h00100093;
    prog[2] = 32'h00208133;
    prog[3] = 32'h00310193;
    prog[4] = 32'h00418213;
    prog[5] = 32'h00520293;

    // Power-on reset
    repeat (2) @(negedge clk);
    chk_reset_values();
    @(negedge clk);
    rst = 1'b0;
    rel = cyc;

    // Straight line, latency 1, no backpressure
    model_pc  = 64'h0;
    model_cnt = 0;
    lat       = 1;
    run_insts(3, 0, 1'b0, first);
    chk("first_req_delay", 64'(first - rel), 64'd2);
    chk("straight_cnt", 64'(o_fetch_cnt), 64'd3);

    // Slow memory with downstream backpressure
    lat = 5;
    run_insts(2, 4, 1'b0, first);

    // Reset while waiting; the late response lands in IDLE and is dropped
    chk("pre_rst_req", 64'(o_i_valid_addr), 64'd1);
    chk("pre_rst_addr", o_i_addr, 64'h14);
    drop = 1'b1;
    @(negedge clk);
    chk("wait_no_req", 64'(o_i_valid_addr), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_values();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    @(negedge clk);
    chk("idle_no_req", 64'(o_i_valid_addr), 64'd0);
    chk("idle_no_valid", 64'(o_inst_valid), 64'd0);
    spur = 1'b1;
    @(negedge clk);
    spur      = 1'b0;
    lat       = 1;
    drop      = 1'b0;
    model_pc  = 64'h0;
    model_cnt = 0;
    prog[2]   = 32'hFFFFFFFF;
    chk("idle_spur_inst", 64'(o_inst), 64'd0);

    // Restart with spurious responses in REQ and HOLD, ending on stop word
    run_insts(3, 1, 1'b1, first);
    chk("post_rst_first_req", 64'(first - rel), 64'd2);

    hits = 0;
    repeat (50) begin
      @(negedge clk);
      if (o_i_valid_addr !== 1'b0 || o_halted !== 1'b1) hits++;
    end
    chk("halt_quiet", 64'(hits), 64'd0);
    chk("halt_cnt", 64'(o_fetch_cnt), 64'd3);
    chk("halt_no_valid", 64'(o_inst_valid), 64'd0);
    chk("halt_sb_empty", 64'(sb.size()), 64'd0);

    // 8-bit PC wraps from 0xFC to 0x00
    @(negedge clk);
    rst8 = 1'b0;
    n8   = 0;
    bad8 = 0;
    w8   = 0;
    exp8 = 8'h00;
    a63  = 8'h00;
    while (n8 < 65 && w8 < 400) begin
      @(negedge clk);
      w8++;
      if (o_i_valid_addr8 === 1'b1) begin
        if (o_i_addr8 !== exp8 || o_inst_valid8 !== 1'b0) bad8++;
        if (n8 == 63) a63 = o_i_addr8;
        n8++;
        exp8 = exp8 + 8'd4;
      end
    end
    chk("wrap_req_count", 64'(n8), 64'd65);
    chk("wrap_seq_errors", 64'(bad8), 64'd0);
    chk("wrap_addr_fc", 64'(a63), 64'hFC);
    chk("wrap_addr_00", 64'(o_i_addr8), 64'h00);
    chk("wrap_cnt", 64'(o_fetch_cnt8), 64'd64);
    chk("wrap_last_pc", 64'(o_pc8), 64'hFC);
    chk("wrap_last_inst", 64'(o_inst8), 64'h13);
    chk("wrap_not_halted", 64'(o_halted8), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
